// File: rtl/frame_config_pkg.sv
// Shared constants and state type for the frame configuration loader.
// Defining FRAME_CONFIG_CHECKSUM_EN adds the CHK state that verifies a trailing checksum word.
package frame_config_pkg;

    localparam logic [31:0] SYNC_WORD   = 32'hFAB0_FAB1;
    localparam logic [31:0] DESYNC_WORD = 32'hFAB0_FAB0;

    localparam int HDR_COL_MSB   = 15;
    localparam int HDR_COL_LSB   = 8;
    localparam int HDR_FRAME_MSB = 4;
    localparam int HDR_FRAME_LSB = 0;

    localparam int COL_W   = HDR_COL_MSB - HDR_COL_LSB + 1;
    localparam int FRAME_W = HDR_FRAME_MSB - HDR_FRAME_LSB + 1;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        STROBE
`ifdef FRAME_CONFIG_CHECKSUM_EN
        ,
        CHK
`endif
    } state_t;

endpackage

// File: rtl/frame_strobe_decoder.sv
// Turns a (column, frame) address plus enable into the one-hot frame latch strobe vector.
module frame_strobe_decoder
    import frame_config_pkg::*;
#(
    parameter int NUM_COLS       = 8,
    parameter int FRAMES_PER_COL = 20
) (
    input  logic [COL_W-1:0]                     col,
    input  logic [FRAME_W-1:0]                   frame,
    input  logic                                 enable,
    output logic [NUM_COLS*FRAMES_PER_COL-1:0]   strobe
);

    localparam int NUM_FRAMES = NUM_COLS * FRAMES_PER_COL;

    logic [31:0] index;

    assign index = 32'(col) * 32'(FRAMES_PER_COL) + 32'(frame);

    always_comb begin
        strobe = '0;
        for (int i = 0; i < NUM_FRAMES; i++) begin
            strobe[i] = enable && (index == 32'(i));
        end
    end

endmodule

// File: rtl/frame_config_loader.sv
// Bitstream loader: sync / header / data / desync framing, broadcasting frame words to tile latches.
// Optional checksum verification is enabled with FRAME_CONFIG_CHECKSUM_EN.
module frame_config_loader
    import frame_config_pkg::*;
#(
    parameter int NUM_COLS       = 8,
    parameter int FRAMES_PER_COL = 20,
    parameter int FRAME_BITS     = 32
) (
    input  logic                                 CLK,
    input  logic                                 resetn,
    input  logic                                 s_valid,
    input  logic [FRAME_BITS-1:0]                s_data,
    output logic                                 s_ready,
    output logic [FRAME_BITS-1:0]                FrameData,
    output logic [NUM_COLS*FRAMES_PER_COL-1:0]   FrameStrobe,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 err
);

    state_t             state;
    state_t             state_next;
    logic               accept;
    logic               is_sync;
    logic               is_desync;
    logic               hdr_in_range;
    logic [COL_W-1:0]   hdr_col;
    logic [FRAME_W-1:0] hdr_frame;
    logic               hdr_bad;

`ifdef FRAME_CONFIG_CHECKSUM_EN
    logic [FRAME_BITS-1:0] checksum;
`endif

    // s_ready is gated by resetn directly so it reads 0 for the whole reset window.
    assign s_ready   = resetn && (state != STROBE);
    assign accept    = s_valid && s_ready;
    assign busy      = (state != IDLE);
    assign is_sync   = (s_data == FRAME_BITS'(SYNC_WORD));
    assign is_desync = (s_data == FRAME_BITS'(DESYNC_WORD));

    assign hdr_in_range =
        (32'(s_data[HDR_COL_MSB:HDR_COL_LSB])     < 32'(NUM_COLS)) &&
        (32'(s_data[HDR_FRAME_MSB:HDR_FRAME_LSB]) < 32'(FRAMES_PER_COL));

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: next state defaults to the current state first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && is_sync) state_next = HDR;
            HDR: begin
                if (accept) begin
                    if (is_desync) begin
`ifdef FRAME_CONFIG_CHECKSUM_EN
                        state_next = CHK;
`else
                        state_next = IDLE;
`endif
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA:    if (accept) state_next = STROBE;
            STROBE:  state_next = HDR;
`ifdef FRAME_CONFIG_CHECKSUM_EN
            CHK:     if (accept) state_next = IDLE;
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            FrameData <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            hdr_col   <= '0;
            hdr_frame <= '0;
            hdr_bad   <= 1'b0;
`ifdef FRAME_CONFIG_CHECKSUM_EN
            checksum  <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (accept) begin
                case (state)
                    IDLE: begin
                        if (is_sync) begin
                            err <= 1'b0;
`ifdef FRAME_CONFIG_CHECKSUM_EN
                            checksum <= '0;
`endif
                        end
                    end
                    HDR: begin
                        if (is_desync) begin
`ifndef FRAME_CONFIG_CHECKSUM_EN
                            done <= 1'b1;
`endif
                        end else begin
                            hdr_col   <= s_data[HDR_COL_MSB:HDR_COL_LSB];
                            hdr_frame <= s_data[HDR_FRAME_MSB:HDR_FRAME_LSB];
                            hdr_bad   <= !hdr_in_range;
                            if (!hdr_in_range) err <= 1'b1;
                        end
                    end
                    DATA: begin
                        FrameData <= s_data;
`ifdef FRAME_CONFIG_CHECKSUM_EN
                        checksum  <= checksum + s_data;
`endif
                    end
`ifdef FRAME_CONFIG_CHECKSUM_EN
                    CHK: begin
                        if (s_data != checksum) err <= 1'b1;
                        done <= 1'b1;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    // An out-of-range header still walks through STROBE but never fires a latch.
    frame_strobe_decoder #(
        .NUM_COLS       (NUM_COLS),
        .FRAMES_PER_COL (FRAMES_PER_COL)
    ) u_decoder (
        .col    (hdr_col),
        .frame  (hdr_frame),
        .enable ((state == STROBE) && !hdr_bad),
        .strobe (FrameStrobe)
    );

endmodule

// File: tb/tb_frame_config_loader.sv
// Scoreboard bench for frame_config_loader; checksum scenarios run when FRAME_CONFIG_CHECKSUM_EN is defined.
module tb_frame_config_loader;

    localparam int NC = 8;
    localparam int FPC = 20;
    localparam int NF = NC * FPC;

    logic          CLK = 1'b0;
    logic          resetn = 1'b0;
    logic          s_valid = 1'b0;
    logic [31:0]   s_data = '0;
    logic          s_ready;
    logic [31:0]   FrameData;
    logic [NF-1:0] FrameStrobe;
    logic          busy;
    logic          done;
    logic          err;

    frame_config_loader #(
        .NUM_COLS       (NC),
        .FRAMES_PER_COL (FPC),
        .FRAME_BITS     (32)
    ) dut (
        .CLK         (CLK),
        .resetn      (resetn),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .FrameData   (FrameData),
        .FrameStrobe (FrameStrobe),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          idx;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail = 0;
    int   strobe_count = 0;
    int   done_count = 0;
    logic done_prev = 1'b0;
    logic ready_watch = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int first_bit(input logic [NF-1:0] v);
        int r = -1;
        for (int i = NF - 1; i >= 0; i--) if (v[i]) r = i;
        return r;
    endfunction

    function automatic logic [31:0] hdr(input int c, input int f);
        logic [7:0] cb = 8'(c);
        logic [4:0] fb = 5'(f);
        return {16'h0000, cb, 3'b000, fb};
    endfunction

    // Output monitor: pops the scoreboard on every strobe.
    always @(negedge CLK) begin
        if (resetn) begin
            if (FrameStrobe != '0) begin
                strobe_count++;
                check("strobe_onehot", 64'($countones(FrameStrobe)), 64'd1);
                check("ready_low_in_strobe", s_ready, 1'b0);
                check("sb_nonempty", sb.size() != 0, 1'b1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("strobe_idx", first_bit(FrameStrobe), e.idx);
                    check("frame_data", FrameData, e.data);
                end
            end else if (ready_watch) begin
                check("ready_outside_strobe", s_ready, 1'b1);
            end
            if (done) begin
                done_count++;
                check("done_single_cycle", done_prev, 1'b0);
            end
            done_prev = done;
        end else begin
            done_prev = 1'b0;
        end
    end

    task automatic send(input logic [31:0] w, input int gap = 0);
        int n = 0;
        s_valid = 1'b1;
        s_data  = w;
        @(negedge CLK);
        while (!s_ready && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 20) check("ready_timeout", s_ready, 1'b1);
        @(posedge CLK);
        #1;
        s_valid = 1'b0;
        repeat (gap) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic write_frame(input int c, input int f, input logic [31:0] d, input int gap = 0);
        exp_t x;
        send(hdr(c, f), gap);
        if (c < NC && f < FPC) begin
            x.idx  = c * FPC + f;
            x.data = d;
            sb.push_back(x);
        end
        send(d, gap);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge CLK);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int s0;

        // Reset state
        #2;
        check("rst_ready", s_ready, 1'b0);
        check("rst_strobe", first_bit(FrameStrobe), -1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_framedata", FrameData, 32'h0);
        repeat (2) @(posedge CLK);
        #3 resetn = 1'b1;
        @(negedge CLK);
        check("ready_after_release", s_ready, 1'b1);
        @(posedge CLK);
        #1;

        // Basic frame, column 2 frame 5 -> bit 45
        d0 = done_count;
        send(32'hFAB0_FAB1);
        @(negedge CLK);
        check("busy_after_sync", busy, 1'b1);
        @(posedge CLK);
        #1;
        write_frame(2, 5, 32'hDEAD_BEEF);
        send(32'hFAB0_FAB0);
        idle_cycles(2);
        check("basic_done_count", done_count - d0, 1);
        check("basic_busy_low", busy, 1'b0);
        check("basic_err", err, 1'b0);
        check("basic_data_hold", FrameData, 32'hDEAD_BEEF);
        check("basic_strobes", strobe_count, 1);

        // Garbage in IDLE, including a stray desync
        d0 = done_count;
        s0 = strobe_count;
        send(32'h1234_5678);
        @(negedge CLK);
        check("garbage1_busy", busy, 1'b0);
        check("garbage1_ready", s_ready, 1'b1);
        @(posedge CLK);
        #1;
        send(32'hFAB0_FAB0);
        @(negedge CLK);
        check("garbage2_busy", busy, 1'b0);
        check("garbage2_ready", s_ready, 1'b1);
        idle_cycles(2);
        check("garbage_no_done", done_count - d0, 0);
        check("garbage_no_strobe", strobe_count - s0, 0);

        // Out-of-range column, out-of-range frame, and a sync word used as header
        s0 = strobe_count;
        send(32'hFAB0_FAB1);
        write_frame(8, 0, 32'h5555_5555);
        idle_cycles(2);
        check("badcol_err", err, 1'b1);
        write_frame(0, 20, 32'h6666_6666);
        write_frame(3, 1, 32'hA5A5_0001);
        send(32'hFAB0_FAB1);
        send(32'h7777_7777);
        idle_cycles(2);
        check("bad_hdr_strobes", strobe_count - s0, 1);
        check("err_sticky", err, 1'b1);
        send(32'hFAB0_FAB0);
        idle_cycles(1);
        check("err_after_desync", err, 1'b1);
        send(32'hFAB0_FAB1);
        @(negedge CLK);
        check("err_cleared_by_sync", err, 1'b0);
        @(posedge CLK);
        #1;
        send(32'hFAB0_FAB0);
        idle_cycles(2);

        // Stalled input, boundary addresses, rewrite
        s0 = strobe_count;
        ready_watch = 1'b1;
        send(32'hFAB0_FAB1, 1);
        write_frame(0, 0, 32'h0000_0001, 1);
        write_frame(NC - 1, FPC - 1, 32'hCAFE_F00D, 1);
        ready_watch = 1'b0;
        check("stall_two_strobes", strobe_count - s0, 2);
        write_frame(0, 0, 32'h0000_0002);
        send(32'hFAB0_FAB0);
        idle_cycles(2);
        check("rewrite_strobes", strobe_count - s0, 3);

        // Reset in the middle of a STROBE cycle
        s0 = strobe_count;
        send(32'hFAB0_FAB1);
        send(hdr(1, 3));
        send(32'hBADC_0FFE);
        #1 resetn = 1'b0;
        #1;
        check("midrst_strobe", first_bit(FrameStrobe), -1);
        check("midrst_ready", s_ready, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_err", err, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_framedata", FrameData, 32'h0);
        @(posedge CLK);
        #3 resetn = 1'b1;
        @(negedge CLK);
        check("midrst_ready_release", s_ready, 1'b1);
        check("midrst_busy_release", busy, 1'b0);
        idle_cycles(3);
        check("midrst_no_strobe", strobe_count - s0, 0);

`ifdef FRAME_CONFIG_CHECKSUM_EN
        // Checksum good then bad
        d0 = done_count;
        send(32'hFAB0_FAB1);
        write_frame(0, 0, 32'd1);
        write_frame(0, 1, 32'd2);
        send(32'hFAB0_FAB0);
        idle_cycles(1);
        check("chk_no_done_before_sum", done_count - d0, 0);
        send(32'd3);
        idle_cycles(2);
        check("chk_good_err", err, 1'b0);
        check("chk_good_done", done_count - d0, 1);
        check("chk_good_busy", busy, 1'b0);
        d0 = done_count;
        send(32'hFAB0_FAB1);
        write_frame(0, 0, 32'd1);
        write_frame(0, 1, 32'd2);
        send(32'hFAB0_FAB0);
        send(32'd4);
        idle_cycles(2);
        check("chk_bad_err", err, 1'b1);
        check("chk_bad_done", done_count - d0, 1);
`endif

        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_config_loader.md
FRAME_CONFIG_LOADER -- requirements
Module: frame_config_loader

Interface
REQ-001 Parameter NUM_COLS, default 8, number of fabric tile columns addressable.
REQ-002 Parameter FRAMES_PER_COL, default 20, configuration frames per column.
REQ-003 Parameter FRAME_BITS, default 32, width of one frame data word.
REQ-004 Port: CLK  input  1  single clock, all state on rising edge.
REQ-005 Port: resetn  input  1  asynchronous active-low reset.
REQ-006 Port: s_valid  input  1  bitstream word valid.
REQ-007 Port: s_data  input  FRAME_BITS  bitstream word.
REQ-008 Port: s_ready  output  1  loader accepts s_data this cycle.
REQ-009 Port: FrameData  output  FRAME_BITS  frame word broadcast to all tile switch matrices.
REQ-010 Port: FrameStrobe  output  NUM_COLS*FRAMES_PER_COL  one-hot frame latch strobe, index col*FRAMES_PER_COL+frame.
REQ-011 Port: busy  output  1  high from sync-word acceptance until return to IDLE.
REQ-012 Port: done  output  1  one-cycle pulse on desync completion.
REQ-013 Port: err  output  1  sticky error flag, cleared only on next sync word or reset.

Function
REQ-014 A word transfers only on a cycle with s_valid and s_ready both high.
REQ-015 States SHALL be IDLE, HDR, DATA, STROBE, and CHK (CHK only when REQ-030 is enabled).
REQ-016 IDLE: s_ready=1; accepted words are discarded until 0xFAB0FAB1 (sync); sync moves to HDR, sets busy, clears err.
REQ-017 HDR: s_ready=1; accepted word 0xFAB0FAB0 (desync) moves to IDLE with done pulsed the following cycle (or to CHK when enabled).
REQ-018 HDR: any other word is a header; col=bits[15:8], frame=bits[4:0]; moves to DATA.
REQ-019 Header with col>=NUM_COLS or frame>=FRAMES_PER_COL sets err; the following data word is consumed but produces no strobe.
REQ-020 DATA: s_ready=1; accepted word registered onto FrameData next cycle; moves to STROBE.
REQ-021 STROBE: s_ready=0; exactly one FrameStrobe bit high for exactly one cycle, FrameData stable throughout; then HDR.
REQ-022 Latency: FrameStrobe asserts on the cycle after the data word's acceptance cycle; FrameData valid from that cycle.
REQ-023 FrameData holds its last value outside STROBE; FrameStrobe is all-zero in every state except STROBE.
REQ-024 Sync word received in HDR or DATA is treated as header/data respectively (no resync); only reset aborts a frame.
REQ-025 s_valid low stalls in any state without state change; no timeout.
REQ-026 Frames may be written in any order and any frame may be rewritten; last write wins in the tile.

Reset
REQ-027 On resetn low: state IDLE, FrameData=0, FrameStrobe=0, busy=0, done=0, err=0, checksum=0, immediately and asynchronously.
REQ-028 Reset asserted during STROBE truncates the strobe immediately; no partial frame is retried after reset release.
REQ-029 s_ready SHALL be 0 while resetn is low and 1 in the first cycle after release.

Configuration
REQ-030 Macro FRAME_CONFIG_CHECKSUM_EN: when defined, every accepted DATA word is added mod 2^32 into a checksum cleared on sync; after desync, state CHK accepts one word; mismatch sets err; done pulses after CHK regardless.
REQ-031 Without FRAME_CONFIG_CHECKSUM_EN: no checksum register, no CHK state, desync goes directly to IDLE.

Structure
REQ-032 Shared package frame_config_pkg SHALL hold SYNC_WORD, DESYNC_WORD, header field bit positions, and the state enum type.
REQ-033 One sub-module, frame_strobe_decoder, SHALL convert (col, frame, enable) into the one-hot FrameStrobe vector; all else in frame_config_loader.

Verification
REQ-034 Sync, header col=2 frame=5, data 0xDEADBEEF, desync -> FrameStrobe bit 45 high one cycle with FrameData=0xDEADBEEF, done pulse, busy low, err=0.
REQ-035 Garbage words 0x12345678, 0xFAB0FAB0 in IDLE -> no strobe, busy stays 0, s_ready stays 1.
REQ-036 Header col=8 (NUM_COLS=8) then data -> no FrameStrobe bit ever set, err=1 until next sync.
REQ-037 s_valid toggling every other cycle through two full frames -> exactly two single-cycle strobes, s_ready=0 during each STROBE cycle only.
REQ-038 resetn pulsed low during STROBE -> FrameStrobe zero in the same cycle, state IDLE, all outputs at reset values.
REQ-039 With FRAME_CONFIG_CHECKSUM_EN: data words 1 and 2, desync, checksum 3 -> err=0; repeat with checksum 4 -> err=1; done pulses in both.
